comparator_85: RTL and testbench

- Registered magnitude comparator with 74x85 cascade semantics. Compares unsigned words A and B, MSB first.
- Combines the result with cascade inputs from a less-significant stage, so stages chain into wider comparators.
- Used as a datapath building block. The result is registered on the system clock, giving one cycle of latency.

---
 rtl/comparator_85.sv | 79 +++++++
 tb/tb_comparator_85.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/comparator_85.sv
// Registered magnitude comparator with 74x85-style cascade inputs.
// Compares unsigned a and b MSB first; when the words are equal the result
// comes from a less-significant stage through igt/ilt/ieq. One cycle latency.
module comparator_85 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ilt,
    input  logic             ieq,
    input  logic             igt,
    output logic             olt,
    output logic             oeq,
    output logic             ogt
);

    // Local magnitude decision for this stage's word
    logic word_gt;
    logic word_lt;

    // Next-state and registered result bits
    logic gt_d, lt_d, eq_d;
    logic gt_q, lt_q, eq_q;

    // Priority scan from MSB down: the first differing bit decides
    always_comb begin
        logic decided;
        decided = 1'b0;
        word_gt = 1'b0;
        word_lt = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (!decided && (a[i] != b[i])) begin
                decided = 1'b1;
                word_gt = a[i];
                word_lt = b[i];
            end
        end
    end

    // Merge the local decision with the cascade inputs
    always_comb begin
        gt_d = 1'b0;
        lt_d = 1'b0;
        eq_d = 1'b0;
        if (word_gt) begin
            gt_d = 1'b1;
        end else if (word_lt) begin
            lt_d = 1'b1;
        end else if (ieq) begin
            // Equal from below dominates any other cascade bits
            eq_d = 1'b1;
        end else begin
            // Non-equal cascade codes follow the 74x85 truth table,
            // including the 000 -> 110 and 110 -> 000 oddities
            gt_d = ~ilt;
            lt_d = ~igt;
        end
    end

    // Result register, cleared asynchronously
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            gt_q <= 1'b0;
            lt_q <= 1'b0;
            eq_q <= 1'b0;
        end else begin
            gt_q <= gt_d;
            lt_q <= lt_d;
            eq_q <= eq_d;
        end
    end

    assign ogt = gt_q;
    assign olt = lt_q;
    assign oeq = eq_q;

endmodule

// File: tb/tb_comparator_85.sv
// Directed and exhaustive check of comparator_85 (WIDTH = 4).
module tb_comparator_85;

    logic       clk;
    logic       nreset;
    logic [3:0] a;
    logic [3:0] b;
    logic       ilt, ieq, igt;
    logic       olt, oeq, ogt;

    int n_cmp;
    int n_bad;

    comparator_85 #(.WIDTH(4)) dut (
        .clk    (clk),
        .nreset (nreset),
        .a      (a),
        .b      (b),
        .ilt    (ilt),
        .ieq    (ieq),
        .igt    (igt),
        .olt    (olt),
        .oeq    (oeq),
        .ogt    (ogt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] cas;  // {igt, ilt, ieq}
        logic [2:0] exp;  // {ogt, olt, oeq}
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {ogt,olt,oeq}=%b, expected %b", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic [2:0] cas);
        a   = va;
        b   = vb;
        igt = cas[2];
        ilt = cas[1];
        ieq = cas[0];
    endtask

    // Independent reference: integer compare, then the cascade truth table
    function automatic logic [2:0] ref_model(input logic [3:0] va, input logic [3:0] vb,
                                             input logic [2:0] cas);
        if (va > vb) return 3'b100;
        if (va < vb) return 3'b010;
        case (cas)
            3'b000: return 3'b110;
            3'b010: return 3'b010;
            3'b100: return 3'b100;
            3'b110: return 3'b000;
            default: return 3'b001;
        endcase
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{"gt_A_3",    4'hA, 4'h3, 3'b001, 3'b100};
        vecs[1]  = '{"lt_3_A",    4'h3, 4'hA, 3'b001, 3'b010};
        vecs[2]  = '{"msb_8_7",   4'h8, 4'h7, 3'b001, 3'b100};
        vecs[3]  = '{"msb_7_8",   4'h7, 4'h8, 3'b001, 3'b010};
        vecs[4]  = '{"casign_gt", 4'h1, 4'h0, 3'b010, 3'b100};
        vecs[5]  = '{"casign_lt", 4'h0, 4'h1, 3'b100, 3'b010};
        vecs[6]  = '{"eq6_000",   4'h6, 4'h6, 3'b000, 3'b110};
        vecs[7]  = '{"eq6_001",   4'h6, 4'h6, 3'b001, 3'b001};
        vecs[8]  = '{"eq6_010",   4'h6, 4'h6, 3'b010, 3'b010};
        vecs[9]  = '{"eq6_011",   4'h6, 4'h6, 3'b011, 3'b001};
        vecs[10] = '{"eq6_100",   4'h6, 4'h6, 3'b100, 3'b100};
        vecs[11] = '{"eq6_101",   4'h6, 4'h6, 3'b101, 3'b001};
        vecs[12] = '{"eq6_110",   4'h6, 4'h6, 3'b110, 3'b000};
        vecs[13] = '{"eq6_111",   4'h6, 4'h6, 3'b111, 3'b001};
        vecs[14] = '{"max_F_0",   4'hF, 4'h0, 3'b001, 3'b100};
        vecs[15] = '{"min_0_F",   4'h0, 4'hF, 3'b001, 3'b010};
        vecs[16] = '{"eqF_001",   4'hF, 4'hF, 3'b001, 3'b001};
        vecs[17] = '{"eq0_000",   4'h0, 4'h0, 3'b000, 3'b110};
        vecs[18] = '{"lsb_E_F",   4'hE, 4'hF, 3'b100, 3'b010};

        // Reset held: outputs stay clear across clock edges
        nreset = 1'b0;
        drive(4'd5, 4'd3, 3'b001);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", {ogt, olt, oeq}, 3'b000);
        end

        // Release between edges; first edge loads a valid result
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", {ogt, olt, oeq}, 3'b100);

        // Asynchronous assertion mid-cycle clears without a clock edge
        #2;
        nreset = 1'b0;
        #1;
        check("reset_async", {ogt, olt, oeq}, 3'b000);
        @(negedge clk);
        nreset = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].a, vecs[i].b, vecs[i].cas);
            @(posedge clk);
            #1;
            check(vecs[i].name, {ogt, olt, oeq}, vecs[i].exp);
        end

        // Latency: consecutive inputs, each visible exactly one edge later
        @(posedge clk);
        #1;
        drive(4'd2, 4'd1, 3'b001);
        @(posedge clk);
        #1;
        check("lat_first", {ogt, olt, oeq}, 3'b100);
        drive(4'd1, 4'd2, 3'b001);
        #2;
        check("lat_no_comb", {ogt, olt, oeq}, 3'b100);
        @(posedge clk);
        #1;
        check("lat_second", {ogt, olt, oeq}, 3'b010);

        // Exhaustive sweep of {igt,ilt,ieq,b,a}, one per clock
        for (int k = 0; k < 2048; k++) begin
            logic [10:0] v;
            v = 11'(k);
            drive(v[3:0], v[7:4], v[10:8]);
            @(posedge clk);
            #1;
            check($sformatf("exh_%0d", k), {ogt, olt, oeq}, ref_model(v[3:0], v[7:4], v[10:8]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
